if_stage: RTL and testbench

Instruction-fetch stage of the MIPS core. Owns the program counter, drives the byte address into the combinational instruction memory, and registers the returned word plus its PC into the IF/ID pipeline register toward decode. Supports backpressure from decode and PC redirection from branch/jump resolution.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ifid_reg.sv | 36 +++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : cpu_pkg
//  Description: Shared constants and types for the MIPS core front end. The
//               IF/ID struct is also used by the decode stage.
//  Revision   : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [0:0] {
        IF_RUN   = 1'b0,
        IF_FAULT = 1'b1
    } if_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } ifid_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module     : ifid_reg
//  Description: IF/ID pipeline register with load / hold / squash control.
//               A squash clears valid and forces the instruction to a nop;
//               the PC fields hold their last value.
//  Revision   : 1.0 - initial release
// ============================================================================
module ifid_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  squash,
    input  ifid_t d,
    output ifid_t q
);

    // Register update: reset, then squash, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q.valid    <= 1'b0;
            q.instr    <= NOP_INSTR;
            q.pc       <= 32'h0000_0000;
            q.pc_plus4 <= 32'h0000_0000;
        end else if (squash) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : ifid_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module     : if_stage
//  Description: Instruction-fetch stage. Owns the PC, addresses the
//               combinational instruction memory and loads the IF/ID register.
//               Handles decode backpressure and branch/jump redirects.
//               Optional macro IF_MISALIGN_TRAP_EN: a misaligned redirect
//               target traps into a sticky FAULT state (exit by reset only);
//               without it the target's low two bits are cleared.
//  Revision   : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instruction_addr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    if_state_t   state;
    if_state_t   state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        load;
    logic        squash;
    logic        advance;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign advance          = !ifid_q.valid || id_ready;
    assign instruction_addr = pc;

    assign ifid_d.valid    = 1'b1;
    assign ifid_d.instr    = instruction;
    assign ifid_d.pc       = pc;
    assign ifid_d.pc_plus4 = pc + PC_STEP;

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state, next-PC and IF/ID control: redirect beats advance beats stall.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        squash     = 1'b0;
        case (state)
            IF_RUN: begin
                if (redirect_valid) begin
                    squash = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
                    if ((redirect_target & ALIGN_MASK) != 32'h0) begin
                        state_next = IF_FAULT;
                    end else begin
                        pc_next = redirect_target;
                    end
`else
                    pc_next = redirect_target & ~ALIGN_MASK;
`endif
                end else if (advance) begin
                    load    = 1'b1;
                    pc_next = pc + PC_STEP;
                end
            end
            IF_FAULT: begin
                squash = 1'b1;
            end
        endcase
    end

    // Count instructions handed to decode; squashed ones are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'h0000_0000;
        end else if (ifid_q.valid && id_ready && !redirect_valid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    ifid_reg u_ifid_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .squash (squash),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign id_valid    = ifid_q.valid;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc_plus4 = ifid_q.pc_plus4;

`ifdef IF_MISALIGN_TRAP_EN
    assign fetch_fault = (state == IF_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module     : tb_if_stage
//  Description: Directed self-checking bench for if_stage with a small
//               combinational instruction memory (word i = 0xA000_0000 | i,
//               except words 0..2 which hold a short program).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instruction = mem[instruction_addr[11:2]];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .instruction_addr (instruction_addr),
        .instruction      (instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .id_ready         (id_ready),
        .id_valid         (id_valid),
        .id_instr         (id_instr),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .fetch_count      (fetch_count),
        .fetch_fault      (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full IF/ID view plus address and counter.
    task automatic check_id(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pcv, input logic [31:0] addr,
                            input logic [31:0] cnt);
        check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, v});
        check({tag, ".instr"}, id_instr, ins);
        if (v) begin
            check({tag, ".pc"}, id_pc, pcv);
            check({tag, ".pc4"}, id_pc_plus4, pcv + 32'd4);
        end
        check({tag, ".addr"}, instruction_addr, addr);
        check({tag, ".cnt"}, fetch_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;

        rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        check("rst.valid", {31'h0, id_valid}, 32'h0);
        check("rst.instr", id_instr, 32'h0);
        check("rst.pc", id_pc, 32'h0);
        check("rst.pc4", id_pc_plus4, 32'h0);
        check("rst.cnt", fetch_count, 32'h0);
        check("rst.addr", instruction_addr, 32'h0);
        check("rst.fault", {31'h0, fetch_fault}, 32'h0);

        // Sequential fetch.
        rst = 1'b0;
        step(); check_id("seq0", 1'b1, 32'h2008_0001, 32'h0, 32'h4, 32'd0);
        step(); check_id("seq1", 1'b1, 32'h2009_0002, 32'h4, 32'h8, 32'd1);

        // Stall three cycles with id_pc = 4.
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); check_id("stall", 1'b1, 32'h2009_0002, 32'h4, 32'h8, 32'd1);
        end
        id_ready = 1'b1;
        step(); check_id("seq2", 1'b1, 32'h0109_5020, 32'h8, 32'hC, 32'd2);
        step(); check_id("seq3", 1'b1, 32'hA000_0003, 32'hC, 32'h10, 32'd3);
        step(); check_id("seq4", 1'b1, 32'hA000_0004, 32'h10, 32'h14, 32'd4);

        // Redirect to 0x40 while id_pc = 0x10.
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step(); check_id("redir.bub", 1'b0, 32'h0, 32'h0, 32'h40, 32'd4);
        redirect_valid = 1'b0;
        step(); check_id("redir.tgt", 1'b1, 32'hA000_0010, 32'h40, 32'h44, 32'd4);

        // Redirect to 0x80 while decode stalls: held instruction dropped.
        redirect_valid = 1'b1; redirect_target = 32'h80; id_ready = 1'b0;
        step(); check_id("rst_st.bub", 1'b0, 32'h0, 32'h0, 32'h80, 32'd4);
        redirect_valid = 1'b0; id_ready = 1'b1;
        step(); check_id("rst_st.tgt", 1'b1, 32'hA000_0020, 32'h80, 32'h84, 32'd4);
        step(); check_id("rst_st.nxt", 1'b1, 32'hA000_0021, 32'h84, 32'h88, 32'd5);

        // Misaligned target 0x102.
        redirect_valid = 1'b1; redirect_target = 32'h102;
`ifdef IF_MISALIGN_TRAP_EN
        step();
        check("mis.fault", {31'h0, fetch_fault}, 32'h1);
        check_id("mis.hold", 1'b0, 32'h0, 32'h0, 32'h88, 32'd5);
        redirect_target = 32'h200;
        step();
        check("mis.fault2", {31'h0, fetch_fault}, 32'h1);
        check_id("mis.ign", 1'b0, 32'h0, 32'h0, 32'h88, 32'd5);
        redirect_valid = 1'b0;
        step();
        check_id("mis.stay", 1'b0, 32'h0, 32'h0, 32'h88, 32'd5);
        rst = 1'b1;
        step();
        check("mis.clr", {31'h0, fetch_fault}, 32'h0);
        check_id("mis.rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst = 1'b0;
        step();
        check_id("mis.rest", 1'b1, 32'h2008_0001, 32'h0, 32'h4, 32'd0);
`else
        step();
        check("mis.fault", {31'h0, fetch_fault}, 32'h0);
        check_id("mis.bub", 1'b0, 32'h0, 32'h0, 32'h100, 32'd5);
        redirect_valid = 1'b0;
        step();
        check_id("mis.tgt", 1'b1, 32'hA000_0040, 32'h100, 32'h104, 32'd5);
`endif

        // Wrap at the top of the address space, then reset mid-run.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        check({"wrap.bub"}, {31'h0, id_valid}, 32'h0);
        check("wrap.addr0", instruction_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        check("wrap.pc", id_pc, 32'hFFFF_FFFC);
        check("wrap.pc4", id_pc_plus4, 32'h0);
        check("wrap.instr", id_instr, 32'hA000_03FF);
        check("wrap.addr1", instruction_addr, 32'h0);
        step();
        check("wrap.pc0", id_pc, 32'h0);
        check("wrap.instr0", id_instr, 32'h2008_0001);
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300; id_ready = 1'b0;
        step();
        check_id("rst2", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        check("rst2.pc", id_pc, 32'h0);
        check("rst2.pc4", id_pc_plus4, 32'h0);
        check("rst2.fault", {31'h0, fetch_fault}, 32'h0);
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        step();
        check_id("rst2.first", 1'b1, 32'h2008_0001, 32'h0, 32'h4, 32'd0);
        step();
        check_id("rst2.second", 1'b1, 32'h2009_0002, 32'h4, 32'h8, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
